// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex font and an index-width helper.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high a..g patterns; entry 15 first so HEX_FONT[n] is the glyph for n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-digit to active-high seven-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS seven-segment driver with shadow/display value
// registers, a blank cycle at the start of every slot and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          ACTIVE_LOW_SEG = 1'b0,
  parameter bit          ACTIVE_LOW_DIG = 1'b0,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = idx_width(REFRESH_DIV);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_INV = {8{ACTIVE_LOW_SEG}};
  localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{ACTIVE_LOW_DIG}};

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   display;
  logic [NUM_DIGITS-1:0][3:0]   shadow;
  logic [NUM_DIGITS-1:0]        display_dp;
  logic [NUM_DIGITS-1:0]        shadow_dp;

  logic                  slot_end;
  logic                  frame_end;
  logic                  blank;
  logic [6:0]            font_segs;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] en_next;

  assign slot_end  = enable && (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Prescaler and slot index; both park at zero while the scan is disabled.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load landing on the frame boundary bypasses the shadow so it is shown
  // from the very next frame instead of waiting a whole extra frame.
  // NOTE: display and shadow are plain flops, not a memory, so they take a
  // defined reset value and the first frame never shows garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display    <= '0;
      display_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else if (load && frame_end) begin
      display    <= value;
      display_dp <= dp_in;
      pending    <= 1'b0;
    end else begin
      if (pending && (frame_end || !enable)) begin
        display    <= shadow;
        display_dp <= shadow_dp;
        pending    <= 1'b0;
      end
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (display[idx]),
    .segs   (font_segs)
  );

  // Digit idx is a leading zero when it and every higher nibble are zero.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    blank = BLANK_LEADING && (idx != '0);
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if ((j >= int'(idx)) && (display[j] != 4'h0)) blank = 1'b0;
    end
  end

  always_comb begin
    seg_next = '0;
    en_next  = '0;
    if (enable) begin
      seg_next[SEG_G:SEG_A] = blank ? 7'h00 : font_segs;
      seg_next[SEG_DP]      = display_dp[idx];
      if (cnt != '0) en_next[idx] = 1'b1;
    end
  end

  // Output registers; polarity is folded in here so reset drives idle levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment    <= SEG_INV;
      digit_en   <= DIG_INV;
      frame_tick <= 1'b0;
    end else begin
      segment    <= seg_next ^ SEG_INV;
      digit_en   <= en_next ^ DIG_INV;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: a frame-phase reference model checked every cycle
// against an active-high and an active-low instance, plus literal scenarios.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        enable = 1'b0;
  logic        load   = 1'b0;
  logic [15:0] value  = '0;
  logic [3:0]  dp_in  = '0;

  logic [7:0] segment_a, segment_b;
  logic [3:0] digit_en_a, digit_en_b;
  logic       pending_a, pending_b, frame_tick_a, frame_tick_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD),
    .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_DIG(1'b0), .BLANK_LEADING(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .value(value), .dp_in(dp_in), .segment(segment_a),
    .digit_en(digit_en_a), .pending(pending_a), .frame_tick(frame_tick_a)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_DIG(1'b1), .BLANK_LEADING(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .value(value), .dp_in(dp_in), .segment(segment_b),
    .digit_en(digit_en_b), .pending(pending_b), .frame_tick(frame_tick_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] digit_look(input logic [15:0] v, input logic [3:0] dp, input int d);
    logic [15:0] above;
    logic [6:0]  s;
    above = v >> (4 * d);
    s = (d > 0 && above == 16'h0) ? 7'h00 : font(above[3:0]);
    return {dp[d], s};
  endfunction

  int          phase = 0;
  logic [15:0] m_disp = '0, m_shadow = '0;
  logic [3:0]  m_disp_dp = '0, m_shadow_dp = '0;
  logic        m_pend = 1'b0;
  logic [7:0]  exp_seg = '0;
  logic [3:0]  exp_en = '0;
  logic        exp_tick = 1'b0;
  logic        boundary;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0;
      m_pend = 1'b0; exp_seg = '0; exp_en = '0; exp_tick = 1'b0;
    end else begin
      boundary = enable && (phase == FRAME - 1);
      exp_seg  = enable ? digit_look(m_disp, m_disp_dp, phase / RD) : 8'h00;
      exp_en   = (enable && (phase % RD) != 0) ? 4'(1 << (phase / RD)) : 4'h0;
      exp_tick = boundary;
      if (load && boundary) begin
        m_disp = value; m_disp_dp = dp_in; m_pend = 1'b0;
      end else begin
        if (m_pend && (boundary || !enable)) begin
          m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pend = 1'b0;
        end
        if (load) begin
          m_shadow = value; m_shadow_dp = dp_in; m_pend = 1'b1;
        end
      end
      phase = enable ? (phase + 1) % FRAME : 0;
    end
  end

  always @(negedge clk) begin
    check("seg_a",  segment_a,    exp_seg);
    check("en_a",   digit_en_a,   exp_en);
    check("pend_a", pending_a,    m_pend);
    check("tick_a", frame_tick_a, exp_tick);
    check("seg_b",  segment_b,    exp_seg ^ 8'hFF);
    check("en_b",   digit_en_b,   exp_en ^ 4'hF);
    check("pend_b", pending_b,    m_pend);
    check("tick_b", frame_tick_b, exp_tick);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = 16'($urandom); dp_in = 4'($urandom);
  endtask

  task automatic wait_pending_low();
    int n = 0;
    while (pending_a && n < 4 * FRAME) begin @(negedge clk); n++; end
    check("pend_clear", pending_a, 1'b0);
  endtask

  task automatic wait_en_a(input logic [3:0] target);
    int n = 0;
    while (digit_en_a !== target && n < 3 * FRAME) begin @(negedge clk); n++; end
    check("wait_en", digit_en_a, target);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != p && n < 3 * FRAME) begin @(negedge clk); n++; end
    check("wait_phase", phase, p);
  endtask

  task automatic check_slots(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < ND; k++) begin
      int n = 0;
      wait_en_a(4'(1 << k));
      check("slot_seg", segment_a, s[k]);
      while (digit_en_a == 4'(1 << k) && n < RD + 2) begin n++; @(negedge clk); end
      check("slot_len", n, RD - 1);
      check("slot_blank", digit_en_a, 4'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg_a",  segment_a,    8'h00);
    check("rst_en_a",   digit_en_a,   4'h0);
    check("rst_pend_a", pending_a,    1'b0);
    check("rst_tick_a", frame_tick_a, 1'b0);
    check("rst_seg_b",  segment_b,    8'hFF);
    check("rst_en_b",   digit_en_b,   4'hF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_seg_a", segment_a,  8'h00);
    check("idle_en_a",  digit_en_a, 4'h0);
    check("idle_en_b",  digit_en_b, 4'hF);

    // Basic decode, then leading-zero blanking with a dp on a blanked digit.
    enable = 1'b1;
    do_load(16'h12AF, 4'b0000);
    check("load_pend", pending_a, 1'b1);
    wait_pending_low();
    check_slots(8'h71, 8'h77, 8'h5B, 8'h06);
    do_load(16'h0030, 4'b0100);
    wait_pending_low();
    check_slots(8'h3F, 8'h4F, 8'h80, 8'h00);

    // Mid-frame load, then an overwrite while still pending.
    wait_en_a(4'b0010);
    do_load(16'h5678, 4'b0000);
    check("mid_pend", pending_a, 1'b1);
    check("mid_old_seg", segment_a, 8'h4F);
    check("mid_old_en", digit_en_a, 4'b0010);
    repeat (2) @(negedge clk);
    do_load(16'h9ABC, 4'b0001);
    wait_pending_low();
    check("mid_tick", frame_tick_a, 1'b1);
    check_slots(8'hB9, 8'h7C, 8'h77, 8'h6F);

    // Load exactly on the frame boundary goes straight to display.
    wait_phase(FRAME - 1);
    do_load(16'hBEEF, 4'b1010);
    check("bnd_pend", pending_a, 1'b0);
    check("bnd_tick", frame_tick_a, 1'b1);
    check_slots(8'h71, 8'hF9, 8'h79, 8'hFC);

    // Active-low instance showing a single 8 in digit 0.
    do_load(16'h0008, 4'b0000);
    wait_pending_low();
    n = 0;
    while (digit_en_b !== 4'b1110 && n < 3 * FRAME) begin @(negedge clk); n++; end
    check("al_en", digit_en_b, 4'b1110);
    check("al_seg", segment_b, 8'h80);
    n = 0;
    while (digit_en_b == 4'b1110 && n < RD + 2) begin n++; @(negedge clk); end
    check("al_len", n, RD - 1);
    check("al_blank", digit_en_b, 4'hF);

    // Disabled scan: outputs idle, pending shadow commits the next cycle.
    enable = 1'b0;
    @(negedge clk);
    do_load(16'h4321, 4'hF);
    check("dis_pend_set", pending_a, 1'b1);
    @(negedge clk);
    check("dis_pend_clr", pending_a, 1'b0);
    check("dis_seg", segment_a, 8'h00);
    check("dis_en", digit_en_a, 4'h0);
    enable = 1'b1;

    // Randomised traffic against the model.
    repeat (600) begin
      @(negedge clk);
      enable = ($urandom_range(15) != 0);
      load   = ($urandom_range(11) == 0);
      value  = 16'($urandom);
      dp_in  = 4'($urandom);
    end
    @(negedge clk);
    enable = 1'b1; load = 1'b0;

    // Asynchronous reset at idx 2, cnt 2 with a load pending.
    wait_phase(9);
    value = 16'h1234; dp_in = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pre_rst_pend", pending_a, 1'b1);
    check("pre_rst_en", digit_en_a, 4'b0100);
    #1 rst_n = 1'b0;
    #1;
    check("arst_seg_a",  segment_a,  8'h00);
    check("arst_en_a",   digit_en_a, 4'h0);
    check("arst_pend_a", pending_a,  1'b0);
    check("arst_seg_b",  segment_b,  8'hFF);
    check("arst_en_b",   digit_en_b, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (digit_en_a == 4'h0 && n < 2 * FRAME);
    check("restart_lat", n, 2);
    check("restart_en", digit_en_a, 4'b0001);
    check("restart_seg", segment_a, 8'h3F);
    repeat (FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
